// File: rtl/alu_muldiv.sv
// alu_muldiv: single-cycle ALU plus iterative multiply / divide unit.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   start, ctrl, A, B,  request (accepted only while busy=0), opcode, operands and
//   shamt               shift amount, all sampled at accept
//   R, hi               result (quotient / low product), remainder / high product
//   cout, ovf, ze       carry/borrow, overflow, R==0
//   busy, done          operation in progress, one-cycle completion pulse
//
// Single-cycle ops complete one cycle after accept. MULT/MULTU (and DIV/DIVU when
// the divider is built) spend WIDTH cycles in StCalc on operand magnitudes, then
// one cycle in StFix applying the sign, and complete WIDTH+2 cycles after accept.
// Define ALU_MULDIV_DIV_EN to build the divider; otherwise codes 10/11 are reserved.
module alu_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] hi,
  output logic             cout,
  output logic             ovf,
  output logic             ze,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OpAnd   = 4'd0;
  localparam logic [3:0] OpOr    = 4'd1;
  localparam logic [3:0] OpAdd   = 4'd2;
  localparam logic [3:0] OpSlt   = 4'd3;
  localparam logic [3:0] OpAddu  = 4'd4;
  localparam logic [3:0] OpSll   = 4'd5;
  localparam logic [3:0] OpSub   = 4'd6;
  localparam logic [3:0] OpSltu  = 4'd7;
  localparam logic [3:0] OpMult  = 4'd8;
  localparam logic [3:0] OpMultu = 4'd9;
  localparam logic [3:0] OpDiv   = 4'd10;
`ifdef ALU_MULDIV_DIV_EN
  localparam logic [3:0] OpDivu  = 4'd11;
`endif
  localparam logic [3:0] OpSrl   = 4'd12;
  localparam logic [3:0] OpSra   = 4'd13;

  localparam logic [SHW-1:0] LastCnt = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;      // {hi, lo} product, or {remainder, quotient}
  logic [WIDTH-1:0]   b_q, b_d;      // multiplicand / divisor magnitude
  logic               sgn_q, sgn_d;  // signed op
  logic               neg_q, neg_d;  // negate product / quotient in StFix
  logic [WIDTH-1:0]   r_q, r_d, hi_q, hi_d;
  logic               cout_q, cout_d, ovf_q, ovf_d, ze_q, ze_d, done_q, done_d;
`ifdef ALU_MULDIV_DIV_EN
  logic               div_q, div_d;          // running op is a divide
  logic               neg_rem_q, neg_rem_d;  // remainder takes dividend sign
  logic               ovf_pend_q, ovf_pend_d; // most-negative / -1
`endif

  // Single-cycle datapath and operand preparation
  logic [WIDTH:0]   add_sum, sub_dif;
  logic [WIDTH-1:0] alu_r, alu_hi, a_mag, b_mag;
  logic             alu_cout, alu_ovf, long_op, sgn_op;

  always_comb begin
    add_sum  = {1'b0, A} + {1'b0, B};
    sub_dif  = {1'b0, A} - {1'b0, B};
    sgn_op   = (ctrl == OpMult) || (ctrl == OpDiv);
    a_mag    = (sgn_op && A[WIDTH-1]) ? -A : A;
    b_mag    = (sgn_op && B[WIDTH-1]) ? -B : B;
    alu_r    = '0;
    alu_hi   = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    long_op  = 1'b0;
    case (ctrl)
      OpAnd:  alu_r = A & B;
      OpOr:   alu_r = A | B;
      OpAdd: begin
        alu_r    = add_sum[WIDTH-1:0];
        alu_cout = add_sum[WIDTH];
        alu_ovf  = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OpSlt:  alu_r = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OpAddu: begin
        alu_r    = add_sum[WIDTH-1:0];
        alu_cout = add_sum[WIDTH];
        alu_ovf  = add_sum[WIDTH];
      end
      OpSll:  alu_r = A << shamt;
      OpSub: begin
        alu_r    = sub_dif[WIDTH-1:0];
        alu_cout = sub_dif[WIDTH];  // borrow
        alu_ovf  = (A[WIDTH-1] != B[WIDTH-1]) && (sub_dif[WIDTH-1] != A[WIDTH-1]);
      end
      OpSltu: alu_r = {{(WIDTH-1){1'b0}}, (A < B)};
      OpMult, OpMultu: long_op = 1'b1;
`ifdef ALU_MULDIV_DIV_EN
      OpDiv, OpDivu: begin
        if (B == '0) begin
          alu_r   = '1;
          alu_hi  = A;
          alu_ovf = 1'b1;
        end else begin
          long_op = 1'b1;
        end
      end
`endif
      OpSrl:  alu_r = A >> shamt;
      OpSra:  alu_r = $signed(A) >>> shamt;
      default: ;  // reserved: all zero
    endcase
  end

  // FSM next-state, iteration and result registers
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_fix;
`ifdef ALU_MULDIV_DIV_EN
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    neg_d    = neg_q;
    r_d      = r_q;
    hi_d     = hi_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    ze_d     = ze_q;
    done_d   = 1'b0;
    mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
    prod_fix = neg_q ? -p_q : p_q;
`ifdef ALU_MULDIV_DIV_EN
    div_d      = div_q;
    neg_rem_d  = neg_rem_q;
    ovf_pend_d = ovf_pend_q;
    // Shifted partial remainder minus divisor; bit WIDTH set means it did not fit
    div_trial  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]} - {1'b0, b_q};
    quo_fix    = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    rem_fix    = neg_rem_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (long_op) begin
            state_d = StCalc;
            cnt_d   = '0;
            p_d     = {{WIDTH{1'b0}}, a_mag};
            b_d     = b_mag;
            sgn_d   = sgn_op;
            neg_d   = sgn_op && (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef ALU_MULDIV_DIV_EN
            div_d      = (ctrl == OpDiv) || (ctrl == OpDivu);
            neg_rem_d  = sgn_op && A[WIDTH-1];
            ovf_pend_d = sgn_op && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
`endif
          end else begin
            r_d    = alu_r;
            hi_d   = alu_hi;
            cout_d = alu_cout;
            ovf_d  = alu_ovf;
            ze_d   = (alu_r == '0);
            done_d = 1'b1;
          end
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) state_d = StFix;
`ifdef ALU_MULDIV_DIV_EN
        if (div_q) begin
          p_d = div_trial[WIDTH] ? {p_q[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        end else
`endif
        begin
          p_d = {mul_sum, p_q[WIDTH-1:1]};
        end
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        cout_d  = 1'b0;
`ifdef ALU_MULDIV_DIV_EN
        if (div_q) begin
          r_d   = quo_fix;
          hi_d  = rem_fix;
          ovf_d = ovf_pend_q;
          ze_d  = (quo_fix == '0);
        end else
`endif
        begin
          r_d   = prod_fix[WIDTH-1:0];
          hi_d  = prod_fix[2*WIDTH-1:WIDTH];
          // Overflow when hi is not the sign (or zero) extension of the low word
          ovf_d = sgn_q ? (prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}})
                        : (prod_fix[2*WIDTH-1:WIDTH] != '0);
          ze_d  = (prod_fix[WIDTH-1:0] == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      p_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      r_q     <= '0;
      hi_q    <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ze_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
      div_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
      r_q     <= r_d;
      hi_q    <= hi_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      ze_q    <= ze_d;
      done_q  <= done_d;
`ifdef ALU_MULDIV_DIV_EN
      div_q      <= div_d;
      neg_rem_q  <= neg_rem_d;
      ovf_pend_q <= ovf_pend_d;
`endif
    end
  end

  assign R    = r_q;
  assign hi   = hi_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign ze   = ze_q;
  assign done = done_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv (WIDTH=32). Expectations for codes
// 10/11 follow whether ALU_MULDIV_DIV_EN is defined for the build.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [3:0]  ctrl;
  logic [31:0] A, B, R, hi;
  logic [4:0]  shamt;
  logic        cout, ovf, ze, busy, done;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0]  c;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic [31:0] r;
    logic        co, ov;
  } alu_vec_t;

  typedef struct packed {
    logic [3:0]  c;
    logic [31:0] a, b, r, h;
    logic        ov;
    logic [7:0]  lat;
  } md_vec_t;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ctrl(ctrl), .A(A), .B(B), .shamt(shamt),
    .R(R), .hi(hi), .cout(cout), .ovf(ovf), .ze(ze), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Every step lands 1 time unit after a rising edge: sample, then drive.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue an op from a tick point and wait (bounded) for done.
  // lat = cycles from accept to done (-1 on timeout); busy_bad flags busy
  // low before done or high in the done cycle.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, output int lat, output bit busy_bad);
    ctrl = c; A = a; B = b; shamt = sh; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    busy_bad = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (done) begin
        lat = k;
        if (busy) busy_bad = 1'b1;
        break;
      end
      if (!busy) busy_bad = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ctrl = '0; A = '0; B = '0; shamt = '0;
    tick(); tick();
    checks++; if (R !== 32'h0)  begin errors++; $display("FAIL reset R: got %h want 0", R); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset hi: got %h want 0", hi); end
    checks++; if ({cout, ovf, ze} !== 3'b001)
      begin errors++; $display("FAIL reset flags cout/ovf/ze: got %b want 001", {cout, ovf, ze}); end
    checks++; if ({busy, done} !== 2'b00)
      begin errors++; $display("FAIL reset busy/done: got %b want 00", {busy, done}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    md_vec_t v [5];
    int lat;
    bit bb;
    v[0] = '{4'd8, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0, 8'd34};
    v[1] = '{4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1, 8'd34};
    v[2] = '{4'd8, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b1, 8'd34};
    v[3] = '{4'd8, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 32'hFFFFFFFF, 1'b0, 8'd34};
    v[4] = '{4'd9, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b1, 8'd34};
    for (int i = 0; i < 5; i++) begin
      run_op(v[i].c, v[i].a, v[i].b, 5'd0, lat, bb);
      checks++; if (lat !== int'(v[i].lat))
        begin errors++; $display("FAIL mult[%0d] latency: got %0d want %0d", i, lat, v[i].lat); end
      checks++; if (bb) begin errors++; $display("FAIL mult[%0d] busy: got bad want clean", i); end
      checks++; if ({hi, R} !== {v[i].h, v[i].r})
        begin errors++; $display("FAIL mult[%0d] hi:R: got %h want %h", i, {hi, R}, {v[i].h, v[i].r}); end
      checks++; if ({cout, ovf, ze} !== {1'b0, v[i].ov, v[i].r == 32'd0})
        begin errors++; $display("FAIL mult[%0d] flags: got %b want %b", i, {cout, ovf, ze},
                                 {1'b0, v[i].ov, v[i].r == 32'd0}); end
      tick();
    end
  endtask

  task automatic test_alu();
    alu_vec_t v [14];
    int lat;
    bit bb;
    v[0]  = '{4'd0,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0, 1'b0};
    v[1]  = '{4'd1,  32'hF0F0F0F0, 32'h0F0F0F0F, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0};
    v[2]  = '{4'd2,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 1'b1};
    v[3]  = '{4'd2,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1, 1'b0};
    v[4]  = '{4'd3,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0, 1'b0};
    v[5]  = '{4'd7,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0, 1'b0};
    v[6]  = '{4'd4,  32'hFFFFFFFF, 32'h00000002, 5'd0,  32'h00000001, 1'b1, 1'b1};
    v[7]  = '{4'd5,  32'h00000001, 32'h0,        5'd31, 32'h80000000, 1'b0, 1'b0};
    v[8]  = '{4'd6,  32'h00000005, 32'h00000007, 5'd0,  32'hFFFFFFFE, 1'b1, 1'b0};
    v[9]  = '{4'd6,  32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b0, 1'b1};
    v[10] = '{4'd13, 32'h80000000, 32'h0,        5'd4,  32'hF8000000, 1'b0, 1'b0};
    v[11] = '{4'd12, 32'h80000000, 32'h0,        5'd4,  32'h08000000, 1'b0, 1'b0};
    v[12] = '{4'd3,  32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1'b0, 1'b0};
    v[13] = '{4'd7,  32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000001, 1'b0, 1'b0};
    for (int i = 0; i < 14; i++) begin
      run_op(v[i].c, v[i].a, v[i].b, v[i].sh, lat, bb);
      checks++; if (lat !== 1 || bb)
        begin errors++; $display("FAIL alu[%0d] latency/busy: got %0d/%0d want 1/0", i, lat, bb); end
      checks++; if (R !== v[i].r)
        begin errors++; $display("FAIL alu[%0d] R: got %h want %h", i, R, v[i].r); end
      checks++; if ({hi, cout, ovf, ze} !== {32'h0, v[i].co, v[i].ov, v[i].r == 32'd0})
        begin errors++; $display("FAIL alu[%0d] hi/cout/ovf/ze: got %h %b want %h %b", i, hi,
                                 {cout, ovf, ze}, 32'h0, {v[i].co, v[i].ov, v[i].r == 32'd0}); end
      tick();
    end
    // Results hold after the done pulse
    checks++; if ({done, R} !== {1'b0, 32'h00000001})
      begin errors++; $display("FAIL hold done/R: got %b/%h want 0/00000001", done, R); end
  endtask

  task automatic test_reserved();
    int lat;
    bit bb;
    run_op(4'd8, 32'hFFFFFFFD, 32'd5, 5'd0, lat, bb);  // leave hi nonzero
    tick();
    for (int c = 14; c <= 15; c++) begin
      run_op(4'(c), 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, lat, bb);
      checks++; if (lat !== 1) begin errors++; $display("FAIL rsv%0d latency: got %0d want 1", c, lat); end
      checks++; if ({R, hi, cout, ovf, ze} !== {64'h0, 3'b001})
        begin errors++; $display("FAIL rsv%0d result: got %h %h %b want 0 0 001", c, R, hi,
                                 {cout, ovf, ze}); end
      tick();
    end
  endtask

  task automatic test_div();
    md_vec_t v [6];
    int lat;
    bit bb;
`ifdef ALU_MULDIV_DIV_EN
    v[0] = '{4'd10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 8'd34};
    v[1] = '{4'd11, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 8'd34};
    v[2] = '{4'd10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 8'd34};
    v[3] = '{4'd10, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 8'd34};
    v[4] = '{4'd11, 32'h00001234, 32'd0,        32'hFFFFFFFF, 32'h00001234, 1'b1, 8'd1};
    v[5] = '{4'd11, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'h00000000, 1'b0, 8'd34};
`else
    v[0] = '{4'd10, 32'hFFFFFFF9, 32'd2,        32'h0, 32'h0, 1'b0, 8'd1};
    v[1] = '{4'd11, 32'd100,      32'd7,        32'h0, 32'h0, 1'b0, 8'd1};
    v[2] = '{4'd10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 8'd1};
    v[3] = '{4'd10, 32'd7,        32'hFFFFFFFE, 32'h0, 32'h0, 1'b0, 8'd1};
    v[4] = '{4'd11, 32'h00001234, 32'd0,        32'h0, 32'h0, 1'b0, 8'd1};
    v[5] = '{4'd11, 32'hFFFFFFFF, 32'd1,        32'h0, 32'h0, 1'b0, 8'd1};
`endif
    for (int i = 0; i < 6; i++) begin
      run_op(v[i].c, v[i].a, v[i].b, 5'd0, lat, bb);
      checks++; if (lat !== int'(v[i].lat) || bb)
        begin errors++; $display("FAIL div[%0d] latency/busy: got %0d/%0d want %0d/0", i, lat, bb,
                                 v[i].lat); end
      checks++; if ({R, hi} !== {v[i].r, v[i].h})
        begin errors++; $display("FAIL div[%0d] R/hi: got %h %h want %h %h", i, R, hi,
                                 v[i].r, v[i].h); end
      checks++; if ({cout, ovf, ze} !== {1'b0, v[i].ov, v[i].r == 32'd0})
        begin errors++; $display("FAIL div[%0d] flags: got %b want %b", i, {cout, ovf, ze},
                                 {1'b0, v[i].ov, v[i].r == 32'd0}); end
      tick();
    end
  endtask

  // start while busy is ignored and does not disturb the running operands
  task automatic test_ignore();
    int lat = -1;
    ctrl = 4'd9; A = 32'd3; B = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) begin
        ctrl = 4'd2; A = 32'h11111111; B = 32'h22222222; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = k;
        break;
      end
      tick();
    end
    start = 1'b0;
    checks++; if (lat !== 34) begin errors++; $display("FAIL ignore latency: got %0d want 34", lat); end
    checks++; if ({hi, R} !== {32'h0, 32'd12})
      begin errors++; $display("FAIL ignore result: got %h %h want 0 0000000c", hi, R); end
    tick();
  endtask

  task automatic test_abort();
    int lat;
    bit bb;
    bit seen = 1'b0;
    run_op(4'd2, 32'd1, 32'd1, 5'd0, lat, bb);  // R=2
    tick();
    ctrl = 4'd9; A = 32'h0000FFFF; B = 32'h0000FFFF; start = 1'b1;
    tick();  // N+1
    start = 1'b0;
    tick(); tick(); tick(); tick();  // N+5
    ctrl = 4'd0; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; start = 1'b1;
    tick();  // N+6
    start = 1'b0;
    checks++; if ({busy, done, R} !== {2'b10, 32'd2})
      begin errors++; $display("FAIL abort ignored start: got %b %b %h want 1 0 00000002",
                               busy, done, R); end
    tick(); tick(); tick(); tick();  // N+10
    rst_n = 1'b0;
    tick();  // N+11
    rst_n = 1'b1;
    checks++; if ({busy, done, R, ze} !== {2'b00, 32'd0, 1'b1})
      begin errors++; $display("FAIL abort reset: got %b %b %h %b want 0 0 0 1", busy, done, R, ze); end
    for (int k = 0; k < 40; k++) begin
      if (done || busy) seen = 1'b1;
      tick();
    end
    checks++; if (seen) begin errors++; $display("FAIL abort late done/busy: got 1 want 0"); end
    // Start on the very first edge after reset release
    run_op(4'd8, 32'd9, 32'd9, 5'd0, lat, bb);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; ctrl = 4'd2; A = 32'd2; B = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({done, busy, R} !== {2'b10, 32'd5})
      begin errors++; $display("FAIL restart: got %b %b %h want 1 0 00000005", done, busy, R); end
    tick();
  endtask

  task automatic test_back_to_back();
    ctrl = 4'd2; A = 32'd1; B = 32'd2; shamt = '0; start = 1'b1;
    tick();
    checks++; if ({done, R} !== {1'b1, 32'd3})
      begin errors++; $display("FAIL b2b first: got %b %h want 1 00000003", done, R); end
    ctrl = 4'd1; A = 32'd4; B = 32'd1;
    tick();
    start = 1'b0;
    checks++; if ({done, R} !== {1'b1, 32'd5})
      begin errors++; $display("FAIL b2b second: got %b %h want 1 00000005", done, R); end
    tick();
    checks++; if ({done, R} !== {1'b0, 32'd5})
      begin errors++; $display("FAIL b2b hold: got %b %h want 0 00000005", done, R); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_alu();
    test_reserved();
    test_div();
    test_ignore();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (>=8, power of two).
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start  input  1  request; accepted only when busy=0.
REQ-007 ctrl  input  4  operation code, sampled at accept.
REQ-008 A, B  input  WIDTH  operands, sampled at accept.
REQ-009 shamt  input  SHW  shift amount, sampled at accept.
REQ-010 R  output  WIDTH  result (quotient / low product).
REQ-011 hi  output  WIDTH  remainder / high product; 0 for other ops.
REQ-012 cout, ovf, ze  output  1 each  carry/borrow, overflow, R==0.
REQ-013 busy  output  1  operation in progress.
REQ-014 done  output  1  one-cycle pulse; R/hi/flags valid from that cycle.

Function
REQ-015 Codes SHALL be: 0 AND, 1 OR, 2 ADD, 3 SLT, 4 ADDU, 5 SLL, 6 SUB, 7 SLTU, 8 MULT, 9 MULTU, 10 DIV, 11 DIVU, 12 SRL, 13 SRA; 14-15 reserved.
REQ-016 FSM states SHALL be IDLE, CALC, FIX; accept only in IDLE.
REQ-017 Single-cycle codes (0-7, 12-15): accept at edge N -> done=1 and results at N+1, FSM stays IDLE, busy never asserts.
REQ-018 Codes 8-11: accept at N -> CALC for WIDTH cycles (one bit per cycle: shift-add multiply, restoring divide on magnitudes), then FIX for one cycle (sign correction) -> done at N+WIDTH+2; busy=1 from N+1 until done, busy=0 in the done cycle.
REQ-019 start while busy=1 SHALL be ignored; operands of running op unchanged.
REQ-020 R, hi, flags SHALL hold last values until next done.
REQ-021 ADD/SUB: ovf = signed overflow, cout = carry-out / borrow; ADDU: cout = carry, ovf = carry; logic/shift/SLT ops: cout=0, ovf=0.
REQ-022 SLT/SLTU: R = 1 if A<B (signed/unsigned) else 0.
REQ-023 Shifts act on A by shamt; SRA replicates A[WIDTH-1].
REQ-024 MULT/MULTU: {hi,R} = full 2*WIDTH product; ovf=1 if hi is not the sign/zero extension of R.
REQ-025 DIV: quotient truncates toward zero, remainder sign = dividend sign; DIVU unsigned.
REQ-026 Divide by zero: done at N+1, R=all ones, hi=A, ovf=1, no CALC.
REQ-027 DIV of most-negative by -1: R=most-negative, hi=0, ovf=1.
REQ-028 Reserved codes: R=0, hi=0, cout=0, ovf=0, ze=1, done at N+1.
REQ-029 ze = (R==0) for every completed op.

Reset
REQ-030 rst_n=0 at an edge SHALL force IDLE, R=0, hi=0, cout=0, ovf=0, ze=1, busy=0, done=0.
REQ-031 Reset mid-CALC/FIX SHALL abort; no done for aborted op; start accepted first edge after rst_n=1.

Configuration
REQ-032 Macro ALU_MULDIV_DIV_EN: defined -> codes 10/11 implemented per REQ-018/025-027; undefined -> divider logic absent, codes 10/11 behave as reserved (REQ-028).

Verification (WIDTH=32)
REQ-033 ADD A=0x7FFFFFFF B=1 -> done at N+1, R=0x80000000, ovf=1, cout=0, ze=0.
REQ-034 MULT A=0xFFFFFFFD B=5 -> done at N+34, hi=0xFFFFFFFF, R=0xFFFFFFF1, ovf=0; busy high N+1..N+33.
REQ-035 DIV A=0xFFFFFFF9 B=2 -> R=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU A=100 B=7 -> R=14, hi=2 (macro defined); macro undefined -> R=0, ze=1 at N+1.
REQ-036 DIVU A=0x1234 B=0 -> done at N+1, R=0xFFFFFFFF, hi=0x1234, ovf=1.
REQ-037 MULTU running, start+AND issued at N+5 -> ignored; rst_n=0 at N+10 -> busy=0, R=0 at N+11, no done thereafter.
REQ-038 SRA A=0x80000000 shamt=4 -> R=0xF8000000; SRL same -> R=0x08000000.
